// File: rtl/rll_keyed_stream_gate.sv
// Key-gated valid/ready stream: one XOR gate per data bit, driven by a
// double-buffered key that is loaded in CHUNK_WIDTH pieces while traffic flows.
module rll_keyed_stream_gate #(
  parameter int                   DATA_WIDTH   = 32,
  parameter int                   KEY_WIDTH    = 32,
  parameter int                   CHUNK_WIDTH  = 8,
  parameter logic [KEY_WIDTH-1:0] KEY_POLARITY = 32'hA5A5_5A5A
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   key_clear,
  input  logic                   key_chunk_valid,
  output logic                   key_chunk_ready,
  input  logic [CHUNK_WIDTH-1:0] key_chunk,
  output logic                   key_loaded,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data
);

  localparam int NUM_CHUNKS = KEY_WIDTH / CHUNK_WIDTH;
  localparam int CNT_W      = $clog2(NUM_CHUNKS + 1);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

  state_t                 state_reg;
  logic [CNT_W-1:0]       count_reg;
  logic [KEY_WIDTH-1:0]   shadow_reg;
  logic [KEY_WIDTH-1:0]   shadow_next;
  logic [KEY_WIDTH-1:0]   active_reg;
  logic                   key_loaded_reg;
  logic                   out_valid_reg;
  logic [DATA_WIDTH-1:0]  out_data_reg;
  logic [DATA_WIDTH-1:0]  gated_data;
  logic                   chunk_fire;
  logic                   in_fire;
  logic                   last_chunk;

  // A clear in the same cycle must win over a chunk, so it masks ready.
  assign key_chunk_ready = (state_reg != COMMIT) && !key_clear;
  assign chunk_fire      = key_chunk_valid && key_chunk_ready;
  assign last_chunk      = (count_reg == CNT_W'(NUM_CHUNKS - 1));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHUNKS; gi++) begin : g_shadow
      assign shadow_next[gi*CHUNK_WIDTH +: CHUNK_WIDTH] =
        (chunk_fire && count_reg == CNT_W'(gi)) ? key_chunk
                                                : shadow_reg[gi*CHUNK_WIDTH +: CHUNK_WIDTH];
    end
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_key_gate
      assign gated_data[gi] = in_data[gi] ^ active_reg[gi] ^ KEY_POLARITY[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      shadow_reg     <= '0;
      active_reg     <= '0;
      key_loaded_reg <= 1'b0;
    end else if (key_clear) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      shadow_reg     <= '0;
      active_reg     <= '0;
      key_loaded_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, LOAD: begin
          if (chunk_fire) begin
            shadow_reg <= shadow_next;
            count_reg  <= count_reg + 1'b1;
            state_reg  <= last_chunk ? COMMIT : LOAD;
          end
        end
        COMMIT: begin
          active_reg     <= shadow_reg;
          key_loaded_reg <= 1'b1;
          count_reg      <= '0;
          state_reg      <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready = !out_valid_reg || out_ready;
  assign in_fire  = in_valid && in_ready;

  // Single output stage; key_clear deliberately leaves the in-flight beat alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (in_fire) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= gated_data;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign key_loaded = key_loaded_reg;
  assign out_valid  = out_valid_reg;
  assign out_data   = out_data_reg;

endmodule

// File: tb/tb_rll_keyed_stream_gate.sv
// Directed scoreboard bench for rll_keyed_stream_gate: the driver queues the
// expected output of each accepted beat, an independent monitor pops and compares.
module tb_rll_keyed_stream_gate;

  localparam logic [31:0] POL = 32'hA5A5_5A5A;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_clear;
  logic        key_chunk_valid;
  logic        key_chunk_ready;
  logic [7:0]  key_chunk;
  logic        key_loaded;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  logic [31:0] cur_exp;
  logic [31:0] exp_q[$];
  int          checks   = 0;
  int          failures = 0;

  rll_keyed_stream_gate dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .key_clear       (key_clear),
    .key_chunk_valid (key_chunk_valid),
    .key_chunk_ready (key_chunk_ready),
    .key_chunk       (key_chunk),
    .key_loaded      (key_loaded),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Inputs are stable at the falling edge, so acceptance is decided there.
  task automatic step();
    @(negedge clk);
    if (rst_n && key_chunk_valid && key_chunk_ready)
      $display("t=%0t chunk accepted %h", $time, key_chunk);
    if (rst_n && in_valid && in_ready) begin
      exp_q.push_back(cur_exp);
      $display("t=%0t beat in %h expect %h", $time, in_data, cur_exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [31:0] k, input logic loaded_before);
    for (int c = 0; c < 4; c++) begin
      key_chunk_valid = 1'b1;
      key_chunk       = k[c*8 +: 8];
      step();
    end
    key_chunk_valid = 1'b0;
    chk("commit_chunk_ready", {31'b0, key_chunk_ready}, 32'd0);
    chk("commit_key_loaded", {31'b0, key_loaded}, {31'b0, loaded_before});
    step();
    chk("after_commit_key_loaded", {31'b0, key_loaded}, 32'd1);
    chk("after_commit_chunk_ready", {31'b0, key_chunk_ready}, 32'd1);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [31:0] e);
    in_valid = 1'b1;
    in_data  = d;
    cur_exp  = e;
    step();
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      $display("t=%0t beat out %h", $time, out_data);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat actual=%h required=none", out_data);
      end else begin
        chk("scoreboard_data", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0; key_clear = 1'b0; key_chunk_valid = 1'b0; key_chunk = 8'h00;
    in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b1; cur_exp = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_key_loaded", {31'b0, key_loaded}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_chunk_ready", {31'b0, key_chunk_ready}, 32'd1);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // No key yet: output is plaintext xor polarity.
    send_beat(32'h0000_0000, 32'hA5A5_5A5A);
    chk("latency1_out_valid", {31'b0, out_valid}, 32'd1);
    chk("nokey_key_loaded", {31'b0, key_loaded}, 32'd0);
    step();

    load_key(32'hA5A5_5A5A, 1'b0);
    send_beat(32'h1234_5678, 32'h1234_5678);
    step();

    // All-ones key: differs from polarity in mask 5A5A_A5A5.
    load_key(32'hFFFF_FFFF, 1'b1);
    send_beat(32'h1234_5678, 32'h486E_F3DD);
    step();

    load_key(32'hA5A5_5A5A, 1'b1);
    send_beat(32'h0BAD_F00D, 32'h0BAD_F00D);

    // Stream under the correct key while key 0000_FFFF loads (corrupt mask A5A5_A5A5).
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h7000_0000 + i * 32'h0101_0011;
      cur_exp  = (i <= 4) ? in_data : (in_data ^ 32'hA5A5_A5A5);
      key_chunk_valid = (i < 4);
      key_chunk       = (i < 2) ? 8'hFF : 8'h00;
      #1;
      chk("stream_in_ready", {31'b0, in_ready}, 32'd1);
      if (i == 4) chk("stream_commit_chunk_ready", {31'b0, key_chunk_ready}, 32'd0);
      step();
    end
    in_valid = 1'b0;
    key_chunk_valid = 1'b0;
    step();

    // key_clear collides with chunk 2; the beat in that cycle uses the old key.
    key_chunk_valid = 1'b1; key_chunk = 8'h5A; step();
    key_chunk = 8'h5A; step();
    key_chunk = 8'hA5; key_clear = 1'b1;
    in_valid = 1'b1; in_data = 32'hCAFE_F00D; cur_exp = 32'hCAFE_F00D ^ 32'hA5A5_A5A5;
    #1;
    chk("clear_chunk_ready", {31'b0, key_chunk_ready}, 32'd0);
    step();
    key_clear = 1'b0; key_chunk_valid = 1'b0;
    in_data = 32'h1357_9BDF; cur_exp = 32'h1357_9BDF ^ POL;
    chk("clear_key_loaded", {31'b0, key_loaded}, 32'd0);
    step();
    in_valid = 1'b0;
    load_key(32'hA5A5_5A5A, 1'b0);
    send_beat(32'h0F0F_F0F0, 32'h0F0F_F0F0);
    step();

    // Backpressure: one beat held for three cycles, then the stream resumes.
    out_ready = 1'b0;
    send_beat(32'h0000_0001, 32'h0000_0001);
    in_valid = 1'b1; in_data = 32'h0000_0002; cur_exp = 32'h0000_0002;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_hold_data", out_data, 32'h0000_0001);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    in_data = 32'h0000_0003; cur_exp = 32'h0000_0003;
    step();
    in_valid = 1'b0;
    step();
    step();

    // Reset mid-load with a beat held in the output register.
    out_ready = 1'b0;
    key_chunk_valid = 1'b1; key_chunk = 8'h5A; step();
    key_chunk = 8'h11; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; cur_exp = 32'hDEAD_BEEF;
    step();
    key_chunk = 8'h22; in_valid = 1'b0; rst_n = 1'b0;
    step();
    exp_q.delete();
    rst_n = 1'b1; key_chunk_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_out_data", out_data, 32'h0);
    chk("midrst_key_loaded", {31'b0, key_loaded}, 32'd0);
    chk("midrst_chunk_ready", {31'b0, key_chunk_ready}, 32'd1);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    send_beat(32'h0000_0000, 32'hA5A5_5A5A);
    step();
    step();

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
